i2s_frame_sched: RTL and testbench

Frame-level controller between i2s_trx and the sample-processing pipeline. It brings the transceiver out of reset and discards startup frames. Each received stereo frame is handed to the pipeline over a valid/ready handshake, and the processed result is returned to the transceiver's tx inputs. A per-frame deadline is enforced: a late result flushes the pipeline, mutes output and increments an underrun counter.

---
 rtl/i2s_frame_sched.sv | 198 +++++++++++++++++++
 tb/tb_i2s_frame_sched.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_frame_sched.sv
// Frame scheduler between an I2S transceiver and a sample pipeline.
// It brings the transceiver out of reset, skips the startup frames, hands each
// stereo frame to the pipeline and returns the result to the tx side.
// A late result or a frame overrun flushes the pipeline, mutes the output and
// counts an underrun.
module i2s_frame_sched #(
  parameter int sample_size     = 16,
  parameter int startup_frames  = 4,
  parameter int deadline_cycles = 2048
) (
  input  logic                   sys_clk,
  input  logic                   reset_n,
  input  logic                   run,
  input  logic                   bypass,
  input  logic                   trx_rx_valid,
  input  logic [sample_size-1:0] trx_rx_l,
  input  logic [sample_size-1:0] trx_rx_r,
  output logic                   trx_enable,
  output logic                   trx_reset,
  output logic [sample_size-1:0] trx_tx_l,
  output logic [sample_size-1:0] trx_tx_r,
  output logic                   proc_in_valid,
  input  logic                   proc_in_ready,
  output logic [sample_size-1:0] proc_in_l,
  output logic [sample_size-1:0] proc_in_r,
  input  logic                   proc_out_valid,
  output logic                   proc_out_ready,
  input  logic [sample_size-1:0] proc_out_l,
  input  logic [sample_size-1:0] proc_out_r,
  output logic                   proc_flush,
  output logic                   running,
  output logic [15:0]            underrun_count
);

  localparam int DL_W = $clog2(deadline_cycles);
  localparam logic [DL_W-1:0] DL_LAST   = DL_W'(deadline_cycles - 1);
  localparam logic [DL_W-1:0] DL_ONE    = DL_W'(1);
  localparam logic [7:0]      SYNC_LAST = 8'(startup_frames - 1);

  typedef enum logic [2:0] {
    IDLE,
    TRX_RST,
    SYNC,
    WAIT_FRAME,
    ISSUE,
    WAIT_RESULT
  } state_t;

  state_t                 state_reg, state_next;
  logic                   rst_cnt_reg, rst_cnt_next;
  logic [7:0]             sync_cnt_reg, sync_cnt_next;
  logic [DL_W-1:0]        dl_cnt_reg, dl_cnt_next;
  logic [sample_size-1:0] tx_l_reg, tx_l_next, tx_r_reg, tx_r_next;
  logic [sample_size-1:0] in_l_reg, in_l_next, in_r_reg, in_r_next;
  logic                   flush_reg, flush_next;
  logic [15:0]            underrun_reg, underrun_next;
  logic                   rx_valid_d_reg;
  logic                   frame_evt_reg;
  logic                   busy;
  logic                   miss;

  // A frame is in flight with the pipeline while issuing or awaiting the result.
  assign busy = (state_reg == ISSUE) || (state_reg == WAIT_RESULT);

  // Deadline expiry or a new frame while busy is a miss, unless the result is
  // accepted on that same cycle.
  assign miss = busy
              && !((state_reg == WAIT_RESULT) && proc_out_valid)
              && ((dl_cnt_reg == DL_LAST) || frame_evt_reg);

  // Registers: rx_valid edge detector, FSM state, counters and datapath.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      rst_cnt_reg    <= 1'b0;
      sync_cnt_reg   <= '0;
      dl_cnt_reg     <= '0;
      tx_l_reg       <= '0;
      tx_r_reg       <= '0;
      in_l_reg       <= '0;
      in_r_reg       <= '0;
      flush_reg      <= 1'b0;
      underrun_reg   <= '0;
      rx_valid_d_reg <= 1'b0;
      frame_evt_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      rst_cnt_reg    <= rst_cnt_next;
      sync_cnt_reg   <= sync_cnt_next;
      dl_cnt_reg     <= dl_cnt_next;
      tx_l_reg       <= tx_l_next;
      tx_r_reg       <= tx_r_next;
      in_l_reg       <= in_l_next;
      in_r_reg       <= in_r_next;
      flush_reg      <= flush_next;
      underrun_reg   <= underrun_next;
      rx_valid_d_reg <= trx_rx_valid;
      frame_evt_reg  <= trx_rx_valid & ~rx_valid_d_reg;
    end
  end

  // Next-state and datapath updates; every target holds unless changed below.
  always_comb begin
    state_next    = state_reg;
    rst_cnt_next  = rst_cnt_reg;
    sync_cnt_next = sync_cnt_reg;
    dl_cnt_next   = dl_cnt_reg;
    tx_l_next     = tx_l_reg;
    tx_r_next     = tx_r_reg;
    in_l_next     = in_l_reg;
    in_r_next     = in_r_reg;
    flush_next    = 1'b0;
    underrun_next = underrun_reg;

    if ((state_reg != IDLE) && !run) begin
      // Stopping abandons any in-flight pipeline work.
      state_next = IDLE;
      tx_l_next  = '0;
      tx_r_next  = '0;
      flush_next = busy;
    end else if (miss) begin
      state_next    = WAIT_FRAME;
      tx_l_next     = '0;
      tx_r_next     = '0;
      flush_next    = 1'b1;
      underrun_next = (underrun_reg == 16'hFFFF) ? underrun_reg : underrun_reg + 16'd1;
    end else begin
      case (state_reg)
        IDLE: begin
          if (run) begin
            state_next   = TRX_RST;
            rst_cnt_next = 1'b0;
          end
        end
        TRX_RST: begin
          rst_cnt_next = 1'b1;
          if (rst_cnt_reg) begin
            state_next    = SYNC;
            sync_cnt_next = '0;
          end
        end
        SYNC: begin
          if (frame_evt_reg) begin
            if (sync_cnt_reg == SYNC_LAST) state_next = WAIT_FRAME;
            else sync_cnt_next = sync_cnt_reg + 8'd1;
          end
        end
        WAIT_FRAME: begin
          if (frame_evt_reg) begin
            if (bypass) begin
              tx_l_next = trx_rx_l;
              tx_r_next = trx_rx_r;
            end else begin
              in_l_next   = trx_rx_l;
              in_r_next   = trx_rx_r;
              dl_cnt_next = '0;
              state_next  = ISSUE;
            end
          end
        end
        ISSUE: begin
          dl_cnt_next = dl_cnt_reg + DL_ONE;
          if (proc_in_ready) state_next = WAIT_RESULT;
        end
        WAIT_RESULT: begin
          dl_cnt_next = dl_cnt_reg + DL_ONE;
          if (proc_out_valid) begin
            tx_l_next = proc_out_l;
            tx_r_next = proc_out_r;
            if (frame_evt_reg) begin
              // Result and next frame coincide: take both, no miss.
              in_l_next   = trx_rx_l;
              in_r_next   = trx_rx_r;
              dl_cnt_next = '0;
              state_next  = ISSUE;
            end else begin
              state_next = WAIT_FRAME;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign trx_reset      = (state_reg == IDLE) || (state_reg == TRX_RST);
  assign trx_enable     = (state_reg != IDLE);
  assign running        = (state_reg == WAIT_FRAME) || busy;
  assign proc_in_valid  = (state_reg == ISSUE);
  assign proc_out_ready = (state_reg == WAIT_RESULT);
  assign trx_tx_l       = tx_l_reg;
  assign trx_tx_r       = tx_r_reg;
  assign proc_in_l      = in_l_reg;
  assign proc_in_r      = in_r_reg;
  assign proc_flush     = flush_reg;
  assign underrun_count = underrun_reg;

endmodule

// File: tb/tb_i2s_frame_sched.sv
// Scoreboard bench for i2s_frame_sched: stimulus pushes expected offers and
// outcomes, a negedge monitor pops and compares when the DUT presents them.
module tb_i2s_frame_sched;
  localparam int SS = 16;
  localparam int SF = 4;
  localparam int DC = 64;
  localparam int K_RES  = 0;
  localparam int K_MISS = 1;
  localparam int K_STOP = 2;

  logic          sys_clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          run = 1'b0, bypass = 1'b0, trx_rx_valid = 1'b0;
  logic [SS-1:0] trx_rx_l = '0, trx_rx_r = '0;
  logic          proc_in_ready = 1'b0, proc_out_valid = 1'b0;
  logic [SS-1:0] proc_out_l = '0, proc_out_r = '0;
  logic          trx_enable, trx_reset, proc_in_valid, proc_out_ready, proc_flush, running;
  logic [SS-1:0] trx_tx_l, trx_tx_r, proc_in_l, proc_in_r;
  logic [15:0]   underrun_count;

  i2s_frame_sched #(.sample_size(SS), .startup_frames(SF), .deadline_cycles(DC)) dut (
    .sys_clk(sys_clk), .reset_n(reset_n), .run(run), .bypass(bypass),
    .trx_rx_valid(trx_rx_valid), .trx_rx_l(trx_rx_l), .trx_rx_r(trx_rx_r),
    .trx_enable(trx_enable), .trx_reset(trx_reset),
    .trx_tx_l(trx_tx_l), .trx_tx_r(trx_tx_r),
    .proc_in_valid(proc_in_valid), .proc_in_ready(proc_in_ready),
    .proc_in_l(proc_in_l), .proc_in_r(proc_in_r),
    .proc_out_valid(proc_out_valid), .proc_out_ready(proc_out_ready),
    .proc_out_l(proc_out_l), .proc_out_r(proc_out_r),
    .proc_flush(proc_flush), .running(running), .underrun_count(underrun_count)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int          kind;
    logic [15:0] l;
    logic [15:0] r;
    logic [15:0] uc;
  } exp_t;

  exp_t        out_q[$];
  logic [31:0] issue_q[$];
  int          n_checks = 0, n_fail = 0;
  int          cyc = 0, issue_cyc = 0, flush_cyc = 0, flush_cnt = 0;
  logic        acc_pending = 1'b0, in_valid_prev = 1'b0;
  logic [15:0] exp_uc = '0, exp_tx_l = '0, exp_tx_r = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Monitor: compares whatever the DUT presents against the scoreboard queues.
  always @(negedge sys_clk) begin : monitor
    exp_t        e;
    logic [31:0] d;
    if (!reset_n) begin
      acc_pending   = 1'b0;
      in_valid_prev = 1'b0;
    end else begin
      if (acc_pending) begin
        acc_pending = 1'b0;
        check("result_queued", 32'(out_q.size() != 0), 1);
        if (out_q.size() != 0) begin
          e = out_q.pop_front();
          check("result_kind", e.kind, K_RES);
          check("tx_l", trx_tx_l, e.l);
          check("tx_r", trx_tx_r, e.r);
          check("underrun_res", underrun_count, e.uc);
        end
      end
      if (proc_in_valid && !in_valid_prev) begin
        issue_cyc = cyc;
        check("offer_expected", 32'(issue_q.size() != 0), 1);
      end
      in_valid_prev = proc_in_valid;
      if (proc_in_valid && proc_in_ready && issue_q.size() != 0) begin
        d = issue_q.pop_front();
        check("proc_in_l", proc_in_l, d[31:16]);
        check("proc_in_r", proc_in_r, d[15:0]);
      end
      if (proc_out_valid && proc_out_ready) acc_pending = 1'b1;
      if (proc_flush) begin
        flush_cyc = cyc;
        flush_cnt++;
        check("flush_queued", 32'(out_q.size() != 0), 1);
        if (out_q.size() != 0) begin
          e = out_q.pop_front();
          check("flush_kind", 32'(e.kind != K_RES), 1);
          check("mute_l", trx_tx_l, e.l);
          check("mute_r", trx_tx_r, e.r);
          check("underrun_flush", underrun_count, e.uc);
          if (e.kind == K_STOP) check("stop_trx_reset", trx_reset, 1);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic push_res(input logic [15:0] l, input logic [15:0] r);
    exp_t e;
    e.kind = K_RES; e.l = l; e.r = r; e.uc = exp_uc;
    out_q.push_back(e);
    exp_tx_l = l; exp_tx_r = r;
  endtask

  task automatic push_flush(input int kind);
    exp_t e;
    if (kind == K_MISS) exp_uc = exp_uc + 16'd1;
    exp_tx_l = '0; exp_tx_r = '0;
    e.kind = kind; e.l = '0; e.r = '0; e.uc = exp_uc;
    out_q.push_back(e);
  endtask

  // One rx_valid pulse several sys_clk long; data scrambled afterwards.
  task automatic frame_event(input logic [15:0] l, input logic [15:0] r);
    trx_rx_l = l; trx_rx_r = r; trx_rx_valid = 1'b1;
    tick(4);
    trx_rx_valid = 1'b0;
    trx_rx_l = 16'($urandom); trx_rx_r = 16'($urandom);
  endtask

  task automatic serve_in(input int stall);
    tick(stall);
    proc_in_ready = 1'b1;
    tick(1);
    proc_in_ready = 1'b0;
  endtask

  task automatic serve_out(input int lat, input logic [15:0] rl, input logic [15:0] rr);
    tick(lat);
    push_res(rl, rr);
    proc_out_l = rl; proc_out_r = rr; proc_out_valid = 1'b1;
    tick(1);
    proc_out_valid = 1'b0;
    proc_out_l = 16'($urandom); proc_out_r = 16'($urandom);
  endtask

  task automatic wait_flush(input int f0, input int bound, input string name);
    for (int i = 0; i < bound && flush_cnt == f0; i++) tick(1);
    check(name, 32'(flush_cnt != f0), 1);
  endtask

  task automatic run_frame(input logic [15:0] l, input logic [15:0] r, input int stall,
                           input int lat, input logic [15:0] rl, input logic [15:0] rr);
    issue_q.push_back({l, r});
    frame_event(l, r);
    serve_in(stall);
    serve_out(lat, rl, rr);
    tick(2);
  endtask

  task automatic miss_timeout(input logic [15:0] l, input logic [15:0] r, input int stall);
    int f0;
    f0 = flush_cnt;
    issue_q.push_back({l, r});
    push_flush(K_MISS);
    frame_event(l, r);
    serve_in(stall);
    wait_flush(f0, DC + 20, "timeout_flush_seen");
    check("deadline_latency", 32'(flush_cyc - issue_cyc), DC);
    tick(1);
    check("flush_one_cycle", proc_flush, 0);
    tick(2);
  endtask

  task automatic startup();
    int rc;
    rc = 0;
    run = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge sys_clk);
      if (trx_reset && trx_enable) rc++;
    end
    @(posedge sys_clk); #1;
    check("trx_rst_cycles", rc, 2);
    check("sync_trx_reset", trx_reset, 0);
    check("sync_trx_enable", trx_enable, 1);
    for (int i = 0; i < SF; i++) begin
      frame_event(16'($urandom), 16'($urandom));
      tick(3);
    end
    check("startup_no_offer", proc_in_valid, 0);
    check("running_after_sync", running, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a, b, c, d;
    int f0;

    // Reset state
    tick(3);
    check("rst_trx_reset", trx_reset, 1);
    check("rst_trx_enable", trx_enable, 0);
    check("rst_tx_l", trx_tx_l, 0);
    check("rst_in_valid", proc_in_valid, 0);
    check("rst_running", running, 0);
    check("rst_underrun", underrun_count, 0);
    reset_n = 1'b1;
    tick(2);
    check("idle_trx_reset", trx_reset, 1);

    startup();

    // Nominal: frame 5 is the first processed one
    run_frame(16'h1234, 16'hABCD, 3, 50, 16'h2468, 16'h579A);
    check("nominal_underrun", underrun_count, 0);

    // Deadline miss, then an on-time result restores tx
    miss_timeout(16'h0F0F, 16'hF0F0, 2);
    run_frame(16'h1111, 16'h2222, 1, 10, 16'h3333, 16'h4444);

    // Frame overrun while waiting for a result: second frame dropped
    f0 = flush_cnt;
    issue_q.push_back({16'h5555, 16'h6666});
    frame_event(16'h5555, 16'h6666);
    serve_in(1);
    tick(5);
    push_flush(K_MISS);
    frame_event(16'h7777, 16'h8888);
    wait_flush(f0, 20, "overrun_flush_seen");
    tick(5);
    check("overrun_no_offer", proc_in_valid, 0);

    // Coincident result and frame event
    issue_q.push_back({16'h0101, 16'h0202});
    frame_event(16'h0101, 16'h0202);
    serve_in(0);
    tick(5);
    trx_rx_l = 16'h0303; trx_rx_r = 16'h0404; trx_rx_valid = 1'b1;
    tick(1);
    issue_q.push_back({16'h0303, 16'h0404});
    push_res(16'hBEEF, 16'hCAFE);
    proc_out_l = 16'hBEEF; proc_out_r = 16'hCAFE; proc_out_valid = 1'b1;
    tick(1);
    proc_out_valid = 1'b0;
    check("coincident_issue", proc_in_valid, 1);
    tick(2);
    trx_rx_valid = 1'b0;
    serve_in(1);
    serve_out(8, 16'hD00D, 16'hF00D);
    tick(2);
    check("coincident_underrun", underrun_count, exp_uc);

    // Bypass: tx follows rx one cycle after the event
    bypass = 1'b1;
    for (int k = 0; k < 2; k++) begin
      a = 16'($urandom); b = 16'($urandom);
      trx_rx_l = a; trx_rx_r = b; trx_rx_valid = 1'b1;
      tick(1);
      check("bypass_before_l", trx_tx_l, exp_tx_l);
      tick(1);
      check("bypass_l", trx_tx_l, a);
      check("bypass_r", trx_tx_r, b);
      exp_tx_l = a; exp_tx_r = b;
      tick(2);
      trx_rx_valid = 1'b0;
      tick(3);
    end
    bypass = 1'b0;

    // Randomized frames: on-time results or timeouts
    for (int k = 0; k < 10; k++) begin
      a = 16'($urandom); b = 16'($urandom); c = 16'($urandom); d = 16'($urandom);
      if ($urandom_range(0, 3) == 3) miss_timeout(a, b, $urandom_range(0, 4));
      else run_frame(a, b, $urandom_range(0, 4), $urandom_range(1, 40), c, d);
    end

    // run=0 while waiting for a result
    issue_q.push_back({16'hAAAA, 16'h5555});
    frame_event(16'hAAAA, 16'h5555);
    serve_in(1);
    tick(3);
    push_flush(K_STOP);
    run = 1'b0;
    tick(1);
    check("stop_trx_reset_now", trx_reset, 1);
    check("stop_running", running, 0);
    check("stop_out_ready", proc_out_ready, 0);
    tick(1);
    check("stop_flush_one_cycle", proc_flush, 0);
    check("stop_underrun_kept", underrun_count, exp_uc);
    tick(3);

    // Restart, then async reset in the middle of ISSUE
    startup();
    check("restart_underrun_kept", underrun_count, exp_uc);
    issue_q.push_back({16'h1357, 16'h2468});
    frame_event(16'h1357, 16'h2468);
    check("issue_before_reset", proc_in_valid, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_in_valid", proc_in_valid, 0);
    check("arst_in_l", proc_in_l, 0);
    check("arst_tx_l", trx_tx_l, 0);
    check("arst_trx_reset", trx_reset, 1);
    check("arst_trx_enable", trx_enable, 0);
    check("arst_running", running, 0);
    check("arst_underrun", underrun_count, 0);
    issue_q.delete();
    exp_uc = '0; exp_tx_l = '0; exp_tx_r = '0;
    tick(2);
    reset_n = 1'b1;
    run = 1'b0;
    tick(4);

    check("out_q_empty", out_q.size(), 0);
    check("issue_q_empty", issue_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
